// File: rtl/bank_reg_pkg.sv
// rtl/bank_reg_pkg.sv - shared defaults and types for the scoreboarded register bank
package bank_reg_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NREGS  = 32;
   localparam int REG_ZERO   = 0;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/bank_reg_rdport.sv
// rtl/bank_reg_rdport.sv - one combinational read port with zero/range masking and busy lookup
// Optional BANKREG_BYPASS_EN adds the same-cycle writeback bypass.
module bank_reg_rdport
   import bank_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREGS  = DEF_NREGS
) (
   input  logic [NREGS*DATA_W-1:0] regs_flat,
   input  logic [NREGS-1:0]        pending,
`ifdef BANKREG_BYPASS_EN
   input  logic                    wr_valid,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rsv_valid,
   input  logic [ADDR_W-1:0]       rsv_addr,
`endif
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_busy
);

   localparam int              IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NREGS);

   logic             in_range;
   logic [IDX_W-1:0] idx;

   assign in_range = ({1'b0, rd_addr} < LIMIT) && (rd_addr != ADDR_W'(REG_ZERO));
   assign idx      = rd_addr[IDX_W-1:0];

   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (in_range) begin
         rd_data = regs_flat[idx*DATA_W +: DATA_W];
         rd_busy = pending[idx];
`ifdef BANKREG_BYPASS_EN
         // wr_valid already implies a nonzero in-range target, so a match implies in_range
         if (wr_valid && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
            if (!(rsv_valid && (rsv_addr == rd_addr)))
               rd_busy = 1'b0;
         end
`endif
      end
   end

endmodule

// File: rtl/bank_reg_scb.sv
// rtl/bank_reg_scb.sv - register bank with two read ports, one write port and pending scoreboard
// Optional BANKREG_BYPASS_EN enables write-to-read bypass in both read ports.
module bank_reg_scb
   import bank_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREGS  = DEF_NREGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              all_idle
);

   localparam int              IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NREGS);

   logic [DATA_W-1:0]       regs_q [NREGS];
   logic [NREGS-1:0]        pending_q;
   logic [NREGS-1:0]        pending_d;
   logic [NREGS*DATA_W-1:0] regs_flat;

   logic             wr_valid;
   logic             rsv_valid;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rsv_idx;

   // Qualifying with rst_n keeps the bypass from leaking data while reset is held
   assign wr_valid  = rst_n && wr_en && ({1'b0, wr_addr} < LIMIT)
                      && (wr_addr != ADDR_W'(REG_ZERO));
   assign rsv_valid = rst_n && rsv_en && ({1'b0, rsv_addr} < LIMIT)
                      && (rsv_addr != ADDR_W'(REG_ZERO));
   assign wr_idx    = wr_addr[IDX_W-1:0];
   assign rsv_idx   = rsv_addr[IDX_W-1:0];

   // Reserve is applied after the clear so a new producer supersedes the retiring one
   always_comb begin
      pending_d = pending_q;
      if (wr_valid)
         pending_d[wr_idx] = 1'b0;
      if (rsv_valid)
         pending_d[rsv_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
         pending_q <= '0;
      end else begin
         if (wr_valid)
            regs_q[wr_idx] <= wr_data;
         pending_q <= pending_d;
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign all_idle = ~|pending_q;

   bank_reg_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rdport1 (
      .regs_flat (regs_flat),
      .pending   (pending_q),
`ifdef BANKREG_BYPASS_EN
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
`endif
      .rd_addr   (rd_addr1),
      .rd_data   (rd_data1),
      .rd_busy   (rd_busy1)
   );

   bank_reg_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rdport2 (
      .regs_flat (regs_flat),
      .pending   (pending_q),
`ifdef BANKREG_BYPASS_EN
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
`endif
      .rd_addr   (rd_addr2),
      .rd_data   (rd_data2),
      .rd_busy   (rd_busy2)
   );

endmodule
